branch_resolve_ctrl: RTL and testbench

//  Sequences branch/jump resolution in EX. Takes the comparator's taken flag plus the predicted outcome.

---
 rtl/br_ctrl_pkg.sv | 30 +++
 rtl/br_target_calc.sv | 45 ++++
 rtl/branch_resolve_ctrl.sv | 160 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : br_ctrl_pkg
//  Description : Shared types and constants for the branch resolution block:
//                FSM state encoding, B-type funct3 codes and the sequential
//                PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package br_ctrl_pkg;

    // Resolution FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } brc_state_e;

    // B-type funct3 encodings (for decoders that feed this block)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Fall-through increment for a 32-bit instruction
    localparam int unsigned PC_STEP = 4;

endpackage : br_ctrl_pkg
`default_nettype wire

// File: rtl/br_target_calc.sv
`default_nettype none
// ============================================================================
//  Module      : br_target_calc
//  Description : Purely combinational resolution of a control-flow op:
//                real taken flag, target address, next PC and the target
//                misalignment flag.
//  Ports       : is_branch/is_jal/is_jalr  op type (one-hot or all zero)
//                br_taken                  comparator result (branches)
//                pc, imm, rs1              operands
//                actual_taken              op really redirects flow
//                target                    computed jump/branch target
//                next_pc                   target if taken, else pc+4
//                misalign                  taken and target not word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module br_target_calc
    import br_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic            actual_taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    logic [XLEN-1:0] w_jalr_sum;

    assign w_jalr_sum   = rs1 + imm;
    assign actual_taken = (is_branch & br_taken) | is_jal | is_jalr;

    // JALR clears bit 0; bit 1 is left intact so misalignment is still seen
    assign target   = is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
    assign next_pc  = actual_taken ? target : (pc + XLEN'(PC_STEP));
    assign misalign = actual_taken & target[1];

endmodule : br_target_calc
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl
//  Description : EX-stage branch/jump resolution. Detects mispredicts,
//                handshakes a corrected PC to fetch, pulses an IF/ID flush
//                and holds EX for FLUSH_CYCLES after the redirect is taken.
//                Misaligned taken targets raise a one-cycle exception pulse
//                instead of a redirect.
//  Ports       : clk, rst_n (sync, active low)
//                ex_*            EX op handshake and operands
//                br_taken        comparator result
//                pred_*          fetch prediction
//                redirect_*      valid/ready redirect to the fetch PC mux
//                flush_ifid      one-cycle IF/ID kill
//                misalign_*      one-cycle misaligned-target exception
//                perf_*          event counters (BR_PERF_CNT_EN builds only)
//  Config      : define BR_PERF_CNT_EN to add perf_branches/perf_mispred.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
    import br_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            br_taken,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    brc_state_e      r_state;
    logic [CNT_W-1:0] r_drain_cnt;

    logic            w_actual_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misalign;
    logic            w_is_cf;
    logic            w_accept;
    logic            w_mispredict;
    logic            w_enter_redirect;

    br_target_calc #(
        .XLEN (XLEN)
    ) u_target_calc (
        .is_branch    (ex_is_branch),
        .is_jal       (ex_is_jal),
        .is_jalr      (ex_is_jalr),
        .br_taken     (br_taken),
        .pc           (ex_pc),
        .imm          (ex_imm),
        .rs1          (ex_rs1),
        .actual_taken (w_actual_taken),
        .target       (w_target),
        .next_pc      (w_next_pc),
        .misalign     (w_misalign)
    );

    // ex_ready is only high in IDLE, so accept implies IDLE
    assign w_is_cf  = ex_is_branch | ex_is_jal | ex_is_jalr;
    assign w_accept = ex_valid & ex_ready;

    assign w_mispredict = (w_actual_taken != pred_taken) |
                          (w_actual_taken & pred_taken & (w_target != pred_target));

    // Misalign wins over mispredict: the exception path flushes without redirect
    assign w_enter_redirect = w_accept & w_is_cf & ~w_misalign & w_mispredict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_drain_cnt    <= '0;
            ex_ready       <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_ifid     <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            flush_ifid   <= 1'b0;
            misalign_exc <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_cf && w_misalign) begin
                        misalign_exc  <= 1'b1;
                        misalign_addr <= w_target;
                        flush_ifid    <= 1'b1;
                    end else if (w_enter_redirect) begin
                        redirect_pc    <= w_next_pc;
                        redirect_valid <= 1'b1;
                        flush_ifid     <= 1'b1;
                        ex_ready       <= 1'b0;
                        r_state        <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        r_drain_cnt    <= CNT_W'(FLUSH_CYCLES - 1);
                        r_state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        ex_ready <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    ex_ready       <= 1'b1;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            if (w_accept && w_is_cf) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (w_enter_redirect) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

endmodule : branch_resolve_ctrl
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_ctrl
//  Description : Directed self-checking bench for branch_resolve_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            br_taken;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_ifid;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
`ifdef BR_PERF_CNT_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispred;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .br_taken       (br_taken),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .misalign_exc   (misalign_exc),
        .misalign_addr  (misalign_addr)
`ifdef BR_PERF_CNT_EN
        ,
        .perf_branches  (perf_branches),
        .perf_mispred   (perf_mispred)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
        ex_pc        = '0;
        ex_imm       = '0;
        ex_rs1       = '0;
        br_taken     = 1'b0;
        pred_taken   = 1'b0;
        pred_target  = '0;
    endtask

    task automatic drive_op(input logic b, input logic j, input logic jr,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1, input logic tk,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid     = 1'b1;
        ex_is_branch = b;
        ex_is_jal    = j;
        ex_is_jalr   = jr;
        ex_pc        = pc;
        ex_imm       = imm;
        ex_rs1       = rs1;
        br_taken     = tk;
        pred_taken   = ptk;
        pred_target  = ptgt;
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_n          = 1'b0;
        redirect_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ex_ready",      32'(ex_ready),       32'd1);
        check("rst_redirect_vld",  32'(redirect_valid), 32'd0);
        check("rst_redirect_pc",   redirect_pc,         32'd0);
        check("rst_flush",         32'(flush_ifid),     32'd0);
        check("rst_misalign",      32'(misalign_exc),   32'd0);
        check("rst_misalign_addr", misalign_addr,       32'd0);
        rst_n = 1'b1;
        tick();

        // 1: BEQ correctly predicted taken -> nothing happens
        drive_op(1, 0, 0, 32'h100, 32'h20, 32'h0, 1, 1, 32'h120);
        tick();
        idle_inputs();
        check("t1_no_redirect", 32'(redirect_valid), 32'd0);
        check("t1_no_flush",    32'(flush_ifid),     32'd0);
        check("t1_ex_ready",    32'(ex_ready),       32'd1);

        // 2: BNE not taken, predicted taken -> redirect to pc+4, ready held low
        drive_op(1, 0, 0, 32'h200, 32'h40, 32'h0, 0, 1, 32'h240);
        tick();
        idle_inputs();
        check("t2_redirect_vld", 32'(redirect_valid), 32'd1);
        check("t2_redirect_pc",  redirect_pc,         32'h204);
        check("t2_flush",        32'(flush_ifid),     32'd1);
        check("t2_ex_ready",     32'(ex_ready),       32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_vld",   32'(redirect_valid), 32'd1);
            check("t2_hold_pc",    redirect_pc,         32'h204);
            check("t2_hold_flush", 32'(flush_ifid),     32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("t2_accepted_vld", 32'(redirect_valid), 32'd0);
        check("t2_drain1_ready", 32'(ex_ready),       32'd0);
        tick();
        check("t2_drain2_ready", 32'(ex_ready),       32'd0);
        tick();
        check("t2_release",      32'(ex_ready),       32'd1);

        // Taken branch with wrong predicted target, negative offset
        drive_op(1, 0, 0, 32'h400, 32'hFFFF_FFF8, 32'h0, 1, 1, 32'h500);
        tick();
        idle_inputs();
        check("tgt_redirect_vld", 32'(redirect_valid), 32'd1);
        check("tgt_redirect_pc",  redirect_pc,         32'h3F8);
        redirect_ready = 1'b1;
        n = 0;
        while (!ex_ready && n < 20) begin
            tick();
            n++;
        end
        check("tgt_stall_cycles", 32'(n), 32'(1 + FLUSH_CYCLES));
        redirect_ready = 1'b0;

        // 3: JALR to misaligned target -> exception, no redirect
        drive_op(0, 0, 1, 32'h300, 32'h4, 32'h1003, 0, 1, 32'h1004);
        tick();
        idle_inputs();
        check("t3_misalign",      32'(misalign_exc),   32'd1);
        check("t3_misalign_addr", misalign_addr,       32'h1006);
        check("t3_flush",         32'(flush_ifid),     32'd1);
        check("t3_no_redirect",   32'(redirect_valid), 32'd0);
        check("t3_ex_ready",      32'(ex_ready),       32'd1);
        tick();
        check("t3_misalign_pulse", 32'(misalign_exc),  32'd0);
        check("t3_flush_pulse",    32'(flush_ifid),    32'd0);

        // 4: JAL wrapping past 2^32, fetch ready immediately
        redirect_ready = 1'b1;
        drive_op(0, 1, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, 0, 32'h0);
        tick();
        idle_inputs();
        check("t4_redirect_pc",  redirect_pc,         32'h10);
        check("t4_redirect_vld", 32'(redirect_valid), 32'd1);
        n = 0;
        while (!ex_ready && n < 20) begin
            tick();
            n++;
        end
        check("t4_stall_cycles", 32'(n), 32'(1 + FLUSH_CYCLES));
        redirect_ready = 1'b0;

        // Op with no control-flow type and a stray prediction -> ignored
        drive_op(0, 0, 0, 32'h600, 32'h8, 32'h0, 0, 1, 32'h608);
        tick();
        idle_inputs();
        check("noop_no_redirect", 32'(redirect_valid), 32'd0);
        check("noop_no_flush",    32'(flush_ifid),     32'd0);

        // 5: reset while in REDIRECT
        drive_op(1, 0, 0, 32'h700, 32'h10, 32'h0, 1, 0, 32'h0);
        tick();
        idle_inputs();
        check("t5_redirect_vld", 32'(redirect_valid), 32'd1);
        check("t5_redirect_pc",  redirect_pc,         32'h710);
`ifdef BR_PERF_CNT_EN
        check("perf_branches", perf_branches, 32'd6);
        check("perf_mispred",  perf_mispred,  32'd4);
`endif
        rst_n = 1'b0;
        tick();
        check("t5_rst_vld",   32'(redirect_valid), 32'd0);
        check("t5_rst_ready", 32'(ex_ready),       32'd1);
        check("t5_rst_flush", 32'(flush_ifid),     32'd0);
        check("t5_rst_pc",    redirect_pc,         32'd0);
`ifdef BR_PERF_CNT_EN
        check("t5_perf_branches", perf_branches, 32'd0);
        check("t5_perf_mispred",  perf_mispred,  32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("t5_post_vld",   32'(redirect_valid), 32'd0);
        check("t5_post_flush", 32'(flush_ifid),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_resolve_ctrl
`default_nettype wire
